// File: rtl/bcd_time_pkg.sv
// bcd_time_pkg
// Shared constants and helpers for the BCD time counter family.
//   BCD_UNITS_MAX / BCD_TENS_MAX : digit limits of a 00-59 field
//   ADJ_*                        : encodings of the two-bit adjust request
//   div_w()                      : counter width for a clock-enable prescaler
`timescale 1ns/1ps
package bcd_time_pkg;

  localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

  localparam logic [1:0] ADJ_NONE = 2'b00;
  localparam logic [1:0] ADJ_UP   = 2'b01;
  localparam logic [1:0] ADJ_DN   = 2'b10;

  // Bits needed to hold 0 .. div-1 (at least one bit).
  function automatic int div_w(input int unsigned div);
    int unsigned span;
    int          w;
    span = (div > 1) ? div - 1 : 1;
    w    = 0;
    while (span != 0) begin
      w++;
      span = span >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_time_counter_field60.sv
// bcd_field60
// One two-digit BCD field counting 00..59 in either direction.
//   clk_100mhz, rst : clock and asynchronous active-high reset
//   en              : step allowed this cycle
//   dir             : 0 = up, 1 = down
//   carry_in        : carry (up) or borrow (down) from the field below;
//                     the field steps only when en and carry_in are both high
//   load_zero       : synchronous clear to 00
//   tens, units     : registered BCD digits
//   carry_out       : carry/borrow to the next field (combinational)
//   is_zero         : field currently reads 00
`timescale 1ns/1ps
module bcd_field60
  import bcd_time_pkg::*;
(
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       carry_in,
  input  logic       load_zero,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry_out,
  output logic       is_zero
);

  logic at_max;

  assign is_zero   = (tens == 4'd0) && (units == 4'd0);
  assign at_max    = (tens == BCD_TENS_MAX) && (units == BCD_UNITS_MAX);
  assign carry_out = carry_in & (dir ? is_zero : at_max);

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (load_zero) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (en && carry_in) begin
      if (!dir) begin
        if (units == BCD_UNITS_MAX) begin
          units <= 4'd0;
          tens  <= (tens == BCD_TENS_MAX) ? 4'd0 : tens + 4'd1;
        end else begin
          units <= units + 4'd1;
        end
      end else begin
        if (units == 4'd0) begin
          units <= BCD_UNITS_MAX;
          tens  <= (tens == 4'd0) ? BCD_TENS_MAX : tens - 4'd1;
        end else begin
          units <= units - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter
// Single-clock multi-field BCD stopwatch/timer core with clock-enable
// prescalers, count up/down, per-field adjust and synchronous clear.
//   clk_100mhz, rst : clock and asynchronous active-high reset
//   run_toggle      : one-cycle pulse, toggles running
//   clr             : synchronous clear of digits and flags
//   mode_down       : 0 = count up, 1 = count down
//   adj, sel        : adjust request (01 up, 10 down) for field sel
//   digits          : packed BCD, field f at [8f+7:8f], tens in high nibble
//   running         : run state
//   adjusting       : an adjust request targets an existing field
//   expired         : sticky, count-down reached zero
//   rollover        : one-cycle pulse when count-up wraps to all-00
`timescale 1ns/1ps
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 1,
  parameter int ADJ_HZ     = 2,
  parameter int NUM_FIELDS = 2,
  parameter int SEL_W      = 2
) (
  input  logic                    clk_100mhz,
  input  logic                    rst,
  input  logic                    run_toggle,
  input  logic                    clr,
  input  logic                    mode_down,
  input  logic [1:0]              adj,
  input  logic [SEL_W-1:0]        sel,
  output logic [8*NUM_FIELDS-1:0] digits,
  output logic                    running,
  output logic                    adjusting,
  output logic                    expired,
  output logic                    rollover
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int ADJ_DIV  = CLK_HZ / ADJ_HZ;
  localparam int TICK_W   = div_w(TICK_DIV);
  localparam int ADJ_W    = div_w(ADJ_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADJ_W-1:0]  ADJ_LAST  = ADJ_W'(ADJ_DIV - 1);

  logic [TICK_W-1:0]     tick_cnt;
  logic [ADJ_W-1:0]      adj_cnt;
  logic                  tick_en;
  logic                  adj_en;
  logic                  adj_act;
  logic                  adj_step;
  logic                  start;
  logic                  tick_step;
  logic                  cnt_step;
  logic                  all_zero;
  logic                  one_left;
  logic                  fld_dir;
  logic [NUM_FIELDS-1:0] fld_en;
  logic [NUM_FIELDS-1:0] fld_cin;
  logic [NUM_FIELDS-1:0] fld_cout;
  logic [NUM_FIELDS-1:0] fld_zero;

  assign tick_en = (tick_cnt == TICK_LAST);
  assign adj_en  = (adj_cnt == ADJ_LAST);

  // An out-of-range sel leaves the block in normal mode.
  assign adj_act  = ((adj == ADJ_UP) || (adj == ADJ_DN)) &&
                    ({1'b0, sel} < (SEL_W + 1)'(NUM_FIELDS));
  assign adj_step = !clr && adj_act && adj_en;
  assign start    = !clr && run_toggle && !running;

  // Ticks lose to clr, adjust and run_toggle in the same cycle.
  assign tick_step = !clr && !run_toggle && running && !adj_act && tick_en;

  assign all_zero = &fld_zero;
  // Value is exactly one: field 0 reads 01 and every higher field is 00.
  assign one_left = (digits[7:0] == 8'h01) &&
                    (&(fld_zero | NUM_FIELDS'(1)));

  // A down tick at all-zero changes no digit; it only expires.
  assign cnt_step = tick_step && !(mode_down && all_zero);
  assign fld_dir  = adj_step ? (adj == ADJ_DN) : mode_down;

  // During adjust only the selected field sees a carry_in, so no carry
  // or borrow reaches its neighbours.
  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    assign fld_en[f] = adj_step || cnt_step;
    if (f == 0) begin : g_lsf
      assign fld_cin[f] = adj_step ? (sel == SEL_W'(f)) : 1'b1;
    end else begin : g_upper
      assign fld_cin[f] = adj_step ? (sel == SEL_W'(f)) : fld_cout[f-1];
    end

    bcd_field60 u_field (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .en         (fld_en[f]),
      .dir        (fld_dir),
      .carry_in   (fld_cin[f]),
      .load_zero  (clr),
      .tens       (digits[8*f+4 +: 4]),
      .units      (digits[8*f   +: 4]),
      .carry_out  (fld_cout[f]),
      .is_zero    (fld_zero[f])
    );
  end

  // Tick prescaler restarts on clr and on start so the first tick after
  // start lands a full period later.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clr || start || tick_en) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      adj_cnt <= '0;
    end else if (adj_en) begin
      adj_cnt <= '0;
    end else begin
      adj_cnt <= adj_cnt + ADJ_W'(1);
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      running   <= 1'b0;
      expired   <= 1'b0;
      rollover  <= 1'b0;
      adjusting <= 1'b0;
    end else begin
      adjusting <= adj_act;
      rollover  <= cnt_step && !mode_down && fld_cout[NUM_FIELDS-1];
      if (clr) begin
        running <= 1'b0;
        expired <= 1'b0;
      end else if (run_toggle) begin
        running <= ~running;
        if (!running) begin
          expired <= 1'b0;
        end
      end else if (tick_step && mode_down && (all_zero || one_left)) begin
        running <= 1'b0;
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
`timescale 1ns/1ps
module tb_bcd_time_counter;

  localparam int CLK_HZ  = 20;
  localparam int TICK_HZ = 1;
  localparam int ADJ_HZ  = 2;
  localparam int NF      = 2;
  localparam int SEL_W   = 2;
  localparam int TDIV    = CLK_HZ / TICK_HZ;
  localparam int ADIV    = CLK_HZ / ADJ_HZ;

  logic              clk_100mhz = 1'b0;
  logic              rst;
  logic              run_toggle;
  logic              clr;
  logic              mode_down;
  logic [1:0]        adj;
  logic [SEL_W-1:0]  sel;
  logic [8*NF-1:0]   digits;
  logic              running;
  logic              adjusting;
  logic              expired;
  logic              rollover;

  bcd_time_counter #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .ADJ_HZ     (ADJ_HZ),
    .NUM_FIELDS (NF),
    .SEL_W      (SEL_W)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .run_toggle (run_toggle),
    .clr        (clr),
    .mode_down  (mode_down),
    .adj        (adj),
    .sel        (sel),
    .digits     (digits),
    .running    (running),
    .adjusting  (adjusting),
    .expired    (expired),
    .rollover   (rollover)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Reference model: each field held as an integer 0..59; counting works
  // on the combined value in seconds-like units of 60**NF.
  int fv [NF];
  bit m_run, m_exp, m_roll, m_adjusting;
  int m_tcnt, m_acnt;
  int m_ticks, m_adj_steps;

  int checks = 0;
  int passed = 0;

  function automatic logic [8*NF-1:0] m_digits();
    logic [8*NF-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) r[8*f +: 8] = {4'(fv[f] / 10), 4'(fv[f] % 10)};
    return r;
  endfunction

  function automatic int m_total();
    int t, w;
    t = 0;
    w = 1;
    for (int f = 0; f < NF; f++) begin
      t = t + fv[f] * w;
      w = w * 60;
    end
    return t;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < NF; f++) fv[f] = 0;
    m_run = 0; m_exp = 0; m_roll = 0; m_adjusting = 0;
    m_tcnt = 0; m_acnt = 0;
  endtask

  task automatic model_edge();
    bit a_act, t_en, a_en, st;
    int tot, maxt;
    a_act = ((adj == 2'b01) || (adj == 2'b10)) && (int'(sel) < NF);
    t_en  = (m_tcnt == TDIV - 1);
    a_en  = (m_acnt == ADIV - 1);
    st    = !clr && run_toggle && !m_run;
    m_acnt = a_en ? 0 : m_acnt + 1;
    m_tcnt = (clr || st || t_en) ? 0 : m_tcnt + 1;
    m_adjusting = a_act;
    m_roll = 0;
    if (clr) begin
      for (int f = 0; f < NF; f++) fv[f] = 0;
      m_run = 0;
      m_exp = 0;
    end else begin
      if (a_act && a_en) begin
        fv[sel] = (fv[sel] + ((adj == 2'b01) ? 1 : 59)) % 60;
        m_adj_steps++;
      end
      if (run_toggle) begin
        if (!m_run) m_exp = 0;
        m_run = !m_run;
      end else if (m_run && !a_act && t_en) begin
        m_ticks++;
        tot  = m_total();
        maxt = 60 ** NF;
        if (!mode_down) begin
          tot++;
          if (tot == maxt) begin
            tot = 0;
            m_roll = 1;
          end
        end else if (tot == 0) begin
          m_exp = 1;
          m_run = 0;
        end else begin
          tot--;
          if (tot == 0) begin
            m_exp = 1;
            m_run = 0;
          end
        end
        for (int f = 0; f < NF; f++) begin
          fv[f] = tot % 60;
          tot = tot / 60;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk_100mhz);
    model_edge();
    @(negedge clk_100mhz);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".digits"},    32'(digits),    32'(m_digits()));
    chk({tag, ".running"},   32'(running),   32'(m_run));
    chk({tag, ".expired"},   32'(expired),   32'(m_exp));
    chk({tag, ".rollover"},  32'(rollover),  32'(m_roll));
    chk({tag, ".adjusting"}, 32'(adjusting), 32'(m_adjusting));
  endtask

  task automatic pulse_rt();
    run_toggle = 1'b1;
    cyc();
    run_toggle = 1'b0;
  endtask

  task automatic do_adjust(input int f, input bit up, input int n);
    adj = up ? 2'b01 : 2'b10;
    sel = SEL_W'(f);
    m_adj_steps = 0;
    for (int i = 0; i < (n + 2) * ADIV && m_adj_steps < n; i++) cyc();
    adj = 2'b00;
  endtask

  task automatic wait_tick(input string tag);
    int start_ticks;
    start_ticks = m_ticks;
    for (int i = 0; i < 2 * TDIV && m_ticks == start_ticks; i++) begin
      cyc();
      chk_all(tag);
    end
  endtask

  initial begin
    rst = 1'b1; run_toggle = 1'b0; clr = 1'b0; mode_down = 1'b0;
    adj = 2'b00; sel = '0;
    m_ticks = 0; m_adj_steps = 0;
    model_reset();
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
    chk_all("reset");
    chk("reset.digits0", 32'(digits), 32'h0);

    // Count up 100 ticks from a fresh start.
    pulse_rt();
    repeat (2000) cyc();
    chk("up100.digits", 32'(digits), 32'h0140);
    chk("up100.running", 32'(running), 32'd1);
    chk_all("up100");

    // Preload 59:58, then two ticks through the wrap.
    do_adjust(0, 1'b1, 18);
    do_adjust(1, 1'b0, 2);
    chk("pre.digits", 32'(digits), 32'h5958);
    chk_all("pre");
    wait_tick("wrap1");
    chk("wrap1.digits", 32'(digits), 32'h5959);
    wait_tick("wrap2");
    chk("wrap2.digits", 32'(digits), 32'h0000);
    chk("wrap2.rollover", 32'(rollover), 32'd1);
    cyc();
    chk("wrap3.rollover", 32'(rollover), 32'd0);
    chk("wrap3.running", 32'(running), 32'd1);
    chk_all("wrap3");

    // Count down from 00:03 to expiry.
    pulse_rt();
    do_adjust(0, 1'b1, 3);
    chk("dn.pre", 32'(digits), 32'h0003);
    mode_down = 1'b1;
    pulse_rt();
    wait_tick("dn1");
    chk("dn1.digits", 32'(digits), 32'h0002);
    wait_tick("dn2");
    chk("dn2.digits", 32'(digits), 32'h0001);
    wait_tick("dn3");
    chk("dn3.digits", 32'(digits), 32'h0000);
    chk("dn3.expired", 32'(expired), 32'd1);
    chk("dn3.running", 32'(running), 32'd0);
    repeat (40) cyc();
    chk("dn_hold.digits", 32'(digits), 32'h0000);
    chk_all("dn_hold");

    // Adjust field 0 down from 00 with no borrow into field 1.
    do_adjust(0, 1'b0, 1);
    chk("adjdn1", 32'(digits), 32'h0059);
    do_adjust(0, 1'b0, 1);
    chk("adjdn2", 32'(digits), 32'h0058);
    do_adjust(0, 1'b0, 1);
    chk("adjdn3", 32'(digits), 32'h0057);
    chk_all("adjdn");

    // clr wins over run_toggle in the same cycle.
    do_adjust(1, 1'b1, 12);
    do_adjust(0, 1'b0, 23);
    chk("set1234", 32'(digits), 32'h1234);
    mode_down = 1'b0;
    pulse_rt();
    repeat (5) cyc();
    chk("run1234.running", 32'(running), 32'd1);
    chk_all("run1234");
    run_toggle = 1'b1;
    clr = 1'b1;
    cyc();
    run_toggle = 1'b0;
    clr = 1'b0;
    chk("clr.digits", 32'(digits), 32'h0);
    chk("clr.running", 32'(running), 32'd0);
    chk("clr.expired", 32'(expired), 32'd0);
    chk_all("clr");

    // Asynchronous reset between clock edges.
    pulse_rt();
    repeat (45) cyc();
    chk("prerst.digits", 32'(digits), 32'h0002);
    #2 rst = 1'b1;
    #1;
    chk("arst.digits", 32'(digits), 32'h0);
    chk("arst.running", 32'(running), 32'd0);
    chk("arst.expired", 32'(expired), 32'd0);
    chk("arst.rollover", 32'(rollover), 32'd0);
    model_reset();
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
    repeat (60) cyc();
    chk("postrst.digits", 32'(digits), 32'h0);
    chk_all("postrst");

    // Randomized operation against the model.
    for (int i = 0; i < 4000; i++) begin
      run_toggle = ($urandom % 40) == 0;
      clr        = ($urandom % 300) == 0;
      if (($urandom % 80) == 0) adj = (($urandom % 3) == 0) ? 2'($urandom % 4) : 2'b00;
      if (($urandom % 60) == 0) sel = SEL_W'($urandom % 4);
      if (($urandom % 100) == 0) mode_down = 1'($urandom % 2);
      cyc();
      chk_all("rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
